aes128_round_ctrl: RTL and testbench
====================================

// Module: aes128_round_ctrl
// PURPOSE
//  Iterative AES-128 sequencer. Drives the combinational `round` datapath once per cycle
//  and holds the state register between rounds. Fetches round keys from an external
//  expanded-key memory (registered read). Handles encrypt and decrypt, one block at a time.
//  Valid/ready handshakes on both the input side and the output side.
// PARAMETERS
//  NR        10   number of rounds (AES-128); counter width = $clog2(NR+1)
//  KEY_AW    4    rk_addr_o width; the memory holds round keys 0..NR
// PORTS
//  clk_i         in   1    single clock, rising edge
//  rst_i         in   1    synchronous, active-high reset
//  in_valid_i    in   1    input block valid
//  in_ready_o    out  1    controller idle, can accept a block
//  data_i        in   128  plaintext (enc) / ciphertext (dec)
//  enc_or_dec_i  in   1    1 = encrypt, 0 = decrypt; sampled at input handshake
//  out_valid_o   out  1    result valid; held until accepted
//  out_ready_i   in   1    downstream accepts result
//  data_o        out  128  ciphertext / plaintext (state register)
//  rk_addr_o     out  4    round-key index to key memory
//  rk_data_i     in   128  round key; valid 1 cycle after rk_addr_o is presented
//  round_state_o out  128  to round.state_i (= state register)
//  round_key_o   out  128  to round.key_i (= rk_data_i pass-through)
//  mix_col_o     out  1    to round.mix_col_i
//  enc_or_dec_o  out  1    to round.enc_or_dec_i (latched mode)
//  round_result_i in  128  from round.state_o
//  busy_o        out  1    high in every state except IDLE
//  round_o       out  4    current round number (0 outside ROUND)
// BEHAVIOUR
//  - Reset: FSM = IDLE; state reg, round counter, mode and rk_addr_o all = 0;
//    out_valid_o = 0; busy_o = 0; in_ready_o = 0 while rst_i is high.
//  - Reset mid-operation aborts the block. The result is discarded and nothing is emitted.
//  - FSM states: IDLE -> KEY0 -> WHITEN -> ROUND -> DONE -> IDLE.
//  - IDLE: in_ready_o = 1. On in_valid_i & in_ready_o: latch data_i into the state
//    register, latch enc_or_dec_i, go to KEY0. Only IDLE accepts input; there is no overlap.
//  - KEY0: rk_addr_o = 0 (enc) or NR (dec).
//  - WHITEN: state <= state ^ rk_data_i. rk_addr_o = first round-key index (1 enc, NR-1 dec).
//    Round counter <= 1.
//  - ROUND, one cycle per round r = 1..NR:
//      state <= round_result_i; round_key_o = rk_data_i.
//      mix_col_o = (r != NR).
//      rk_addr_o advances each cycle: +1 (enc) / -1 (dec), saturating at NR (enc) / 0 (dec).
//      At r == NR go to DONE; otherwise r <= r+1.
//  - mix_col_o = 0 and round_o = 0 in every state other than ROUND.
//  - DONE: out_valid_o = 1 and data_o = state, held stable while out_ready_i = 0.
//    On out_ready_i, go to IDLE next cycle.
//  - Latency: handshake at cycle T gives out_valid_o at T+NR+3 (13 for NR = 10),
//    assuming out_ready_i is already high. Throughput: 1 block per NR+4 cycles.
//  - Inputs presented while not in IDLE are ignored (in_ready_o = 0).
//  - enc_or_dec_o stays constant for the whole block, even if enc_or_dec_i changes.
// TESTING (bench models the key memory as a registered ROM of the expanded keys)
//  1 key 2b7e151628aed2a6abf7158809cf4f3c, enc pt 3243f6a8885a308d313198a2e0370734
//    -> data_o 3925841d02dc09fbdc118597196a0b32, out_valid_o rises exactly 13 cycles
//    after the handshake.
//  2 key 000102..0f, dec ct 69c4e0d86a7b0430d8cdb78070b4c55a
//    -> data_o 00112233445566778899aabbccddeeff; rk_addr_o sequence 10,9,..,0.
//  3 Enc as in 1 with out_ready_i held low for 20 cycles -> out_valid_o and data_o
//    stable; in_ready_o = 0 throughout.
//  4 in_valid_i pulsed with another block during ROUND -> ignored; first result correct.
//    Then back-to-back blocks -> second accepted 1 cycle after the output handshake.
//  5 rst_i asserted at round 5 -> next cycle IDLE, busy_o = 0, out_valid_o never rises.
//    A fresh block afterwards gives the correct result.
//  6 Check mix_col_o = 1 for rounds 1..9 and 0 for round 10 in both modes;
//    round_o counts 1..10.

Source files
------------

// File: rtl/aes128_round_ctrl_if.sv
// Host-side block handshake for the iterative AES-128 sequencer.
// Input block plus mode in, result block out, each with valid/ready.
interface aes128_round_ctrl_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] data_i;
  logic         enc_or_dec_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] data_o;

  modport slave (
    input  in_valid_i,
    input  data_i,
    input  enc_or_dec_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output data_o
  );

  modport master (
    output in_valid_i,
    output data_i,
    output enc_or_dec_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  data_o
  );
endinterface

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 round sequencer: one round per cycle through an
// external combinational round datapath and a registered key memory.
module aes128_round_ctrl #(
  parameter  int NR     = 10,
  parameter  int KEY_AW = 4,
  localparam int CW     = $clog2(NR + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  aes128_round_ctrl_if.slave  bus,
  output logic [KEY_AW-1:0]   rk_addr_o,
  input  logic [127:0]        rk_data_i,
  output logic [127:0]        round_state_o,
  output logic [127:0]        round_key_o,
  output logic                mix_col_o,
  output logic                enc_or_dec_o,
  input  logic [127:0]        round_result_i,
  output logic                busy_o,
  output logic [CW-1:0]       round_o
);

  typedef enum logic [2:0] {
    IDLE, KEY0, WHITEN, ROUND, DONE
  } state_t;

  state_t              fsm;
  state_t              fsm_nxt;
  logic [127:0]        st;
  logic [CW-1:0]       rnd;
  logic                mode;
  logic [KEY_AW-1:0]   addr;
  logic [KEY_AW-1:0]   addr_step;
  logic                take;
  logic                last;

  assign take = (fsm == IDLE) && bus.in_valid_i;
  assign last = (rnd == CW'(NR));

  always_ff @(posedge clk_i) begin
    if (rst_i) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (take) fsm_nxt = KEY0;
      KEY0:    fsm_nxt = WHITEN;
      WHITEN:  fsm_nxt = ROUND;
      ROUND:   if (last) fsm_nxt = DONE;
      DONE:    if (bus.out_ready_i) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // Key index runs one step ahead of the round using it (memory latency).
  always_comb begin
    addr_step = addr;
    if (mode) begin
      if (addr != KEY_AW'(NR)) addr_step = addr + KEY_AW'(1);
    end else begin
      if (addr != '0) addr_step = addr - KEY_AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st   <= '0;
      rnd  <= '0;
      mode <= 1'b0;
      addr <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (take) begin
            st   <= bus.data_i;
            mode <= bus.enc_or_dec_i;
            addr <= bus.enc_or_dec_i ? '0 : KEY_AW'(NR);
          end
        end
        KEY0: begin
          addr <= mode ? KEY_AW'(1) : KEY_AW'(NR - 1);
        end
        WHITEN: begin
          st   <= st ^ rk_data_i;
          rnd  <= CW'(1);
          addr <= addr_step;
        end
        ROUND: begin
          st   <= round_result_i;
          addr <= addr_step;
          if (!last) rnd <= rnd + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = (fsm == IDLE) && !rst_i;
  assign bus.out_valid_o = (fsm == DONE);
  assign bus.data_o      = st;
  assign rk_addr_o       = addr;
  assign round_state_o   = st;
  assign round_key_o     = rk_data_i;
  assign mix_col_o       = (fsm == ROUND) && !last;
  assign enc_or_dec_o    = mode;
  assign busy_o          = (fsm != IDLE);
  assign round_o         = (fsm == ROUND) ? rnd : '0;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: software AES round and key-memory model,
// table-driven vectors with a result scoreboard plus corner-case sequences.
module tb_aes128_round_ctrl;

  localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KB = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes128_round_ctrl_if bus();

  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] round_state;
  logic [127:0] round_key;
  logic [127:0] round_result;
  logic         mix_col;
  logic         enc_or_dec;
  logic         busy;
  logic [3:0]   round;

  aes128_round_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .rk_addr_o      (rk_addr),
    .rk_data_i      (rk_data),
    .round_state_o  (round_state),
    .round_key_o    (round_key),
    .mix_col_o      (mix_col),
    .enc_or_dec_o   (enc_or_dec),
    .round_result_i (round_result),
    .busy_o         (busy),
    .round_o        (round)
  );

  logic [7:0]   sbox [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] ks [2][11];
  int           key_sel = 0;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    rk_data <= (rk_addr <= 4'd10) ? ks[key_sel][rk_addr] : '0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] aes_round(
    input logic [127:0] s, input logic [127:0] k,
    input logic mc, input logic enc);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[c*4+r] = enc ? sbox[b[((c+r)%4)*4+r]]
                       : inv_sbox[b[((c-r+4)%4)*4+r]];
    if (enc && mc)
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gm(a0,2) ^ gm(a1,3) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gm(a1,2) ^ gm(a2,3) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gm(a2,2) ^ gm(a3,3);
        t[4*c+3] = gm(a0,3) ^ a1 ^ a2 ^ gm(a3,2);
      end
    for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    if (!enc && mc)
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gm(a0,14) ^ gm(a1,11) ^ gm(a2,13) ^ gm(a3,9);
        t[4*c+1] = gm(a0,9) ^ gm(a1,14) ^ gm(a2,11) ^ gm(a3,13);
        t[4*c+2] = gm(a0,13) ^ gm(a1,9) ^ gm(a2,14) ^ gm(a3,11);
        t[4*c+3] = gm(a0,11) ^ gm(a1,13) ^ gm(a2,9) ^ gm(a3,14);
      end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  assign round_result = aes_round(round_state, round_key, mix_col, enc_or_dec);

  task automatic init_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rol(inv,1) ^ rol(inv,2) ^ rol(inv,3) ^ rol(inv,4) ^ 8'h63;
      sbox[x] = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  task automatic expand(input int idx, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      ks[idx][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_enc(input int idx, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ ks[idx][0];
    for (int r = 1; r <= 10; r++)
      s = aes_round(s, ks[idx][r], r != 10, 1'b1);
    return s;
  endfunction

  typedef struct {
    int           ksel;
    logic         enc;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t         tv [$];
  logic [127:0] exp_q [$];
  int           total = 0;
  int           passed = 0;
  logic         cur_mode;
  int           hs_cyc;
  logic [3:0]   addr_tr [16];
  logic         mix_tr [16];
  logic [3:0]   rnd_tr [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h want %h", n, act, want);
  endtask

  task automatic send(input int ksel, input logic enc,
                      input logic [127:0] din, input logic [127:0] dout);
    int n;
    n = 0;
    key_sel = ksel;
    while (!bus.in_ready_o && n < 50) begin
      step();
      n++;
    end
    chk("send_ready", bus.in_ready_o, 1);
    bus.in_valid_i   = 1'b1;
    bus.data_i       = din;
    bus.enc_or_dec_i = enc;
    cur_mode = enc;
    exp_q.push_back(dout);
    step();
    hs_cyc = cyc;
    bus.in_valid_i   = 1'b0;
    bus.enc_or_dec_i = ~enc;
    bus.data_i       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic recv(input int hold);
    logic [127:0] held;
    logic [127:0] want;
    logic bad, mbad;
    int n, lat;
    bad = 0; mbad = 0; n = 0;
    for (int i = 0; i < 16; i++) begin
      addr_tr[i] = 4'hf; mix_tr[i] = 1'b0; rnd_tr[i] = 4'hf;
    end
    while (!bus.out_valid_o && n < 60) begin
      lat = cyc - hs_cyc + 1;
      if (lat >= 0 && lat < 16) begin
        addr_tr[lat] = rk_addr;
        mix_tr[lat]  = mix_col;
        rnd_tr[lat]  = round;
      end
      if (enc_or_dec !== cur_mode) mbad = 1;
      step();
      n++;
    end
    chk("out_valid", bus.out_valid_o, 1);
    chk("latency", cyc - hs_cyc + 1, 13);
    chk("mode_held", mbad, 0);
    held = bus.data_o;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!bus.out_valid_o || bus.data_o !== held || bus.in_ready_o || !busy)
        bad = 1;
    end
    if (hold > 0) chk("hold_stable", bad, 0);
    bus.out_ready_i = 1'b1;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk("data_o", held, want);
    step();
  endtask

  task automatic check_trace(input logic enc);
    logic [47:0] a_act, a_exp, r_act, r_exp;
    logic [11:0] m_act, m_exp;
    int ea;
    a_act = '0; a_exp = '0; r_act = '0; r_exp = '0; m_act = '0; m_exp = '0;
    for (int L = 1; L <= 12; L++) begin
      ea = enc ? ((L - 1 > 10) ? 10 : L - 1) : ((L >= 11) ? 0 : 11 - L);
      a_act = {a_act[43:0], addr_tr[L]};
      a_exp = {a_exp[43:0], 4'(ea)};
      r_act = {r_act[43:0], rnd_tr[L]};
      r_exp = {r_exp[43:0], (L >= 3) ? 4'(L - 2) : 4'd0};
      m_act = {m_act[10:0], mix_tr[L]};
      m_exp = {m_exp[10:0], (L >= 3 && L <= 11)};
    end
    chk("rk_addr_seq", a_act, a_exp);
    chk("round_seq", r_act, r_exp);
    chk("mix_col_seq", m_act, m_exp);
  endtask

  initial begin
    logic [127:0] rp;
    int prev, n;
    logic seen;
    bus.in_valid_i   = 1'b0;
    bus.data_i       = '0;
    bus.enc_or_dec_i = 1'b0;
    bus.out_ready_i  = 1'b1;
    init_tables();
    expand(0, KA);
    expand(1, KB);

    rp = {$urandom, $urandom, $urandom, $urandom};
    tv.push_back('{0, 1'b1, P1, C1});
    tv.push_back('{0, 1'b0, C1, P1});
    tv.push_back('{1, 1'b1, P2, C2});
    tv.push_back('{1, 1'b0, C2, P2});
    tv.push_back('{0, 1'b1, rp, ref_enc(0, rp)});
    rp = {$urandom, $urandom, $urandom, $urandom};
    tv.push_back('{1, 1'b0, ref_enc(1, rp), rp});

    step();
    step();
    chk("rst_in_ready", bus.in_ready_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_rk_addr", rk_addr, 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_round_mix", {round, mix_col}, 0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", bus.in_ready_o, 1);

    foreach (tv[i]) begin
      send(tv[i].ksel, tv[i].enc, tv[i].din, tv[i].dout);
      recv(0);
      check_trace(tv[i].enc);
    end

    bus.out_ready_i = 1'b0;
    send(0, 1'b1, P1, C1);
    recv(20);

    send(0, 1'b1, P1, C1);
    for (int i = 0; i < 4; i++) step();
    bus.in_valid_i   = 1'b1;
    bus.data_i       = P2;
    bus.enc_or_dec_i = 1'b0;
    chk("busy_in_ready", bus.in_ready_o, 0);
    step();
    step();
    bus.in_valid_i = 1'b0;
    recv(0);
    prev = hs_cyc;
    chk("b2b_ready", bus.in_ready_o, 1);
    send(1, 1'b1, P2, C2);
    chk("b2b_gap", hs_cyc - prev, 14);
    recv(0);

    send(1, 1'b1, P2, C2);
    n = 0;
    while (round !== 4'd5 && n < 30) begin
      step();
      n++;
    end
    chk("reach_round5", round, 5);
    rst = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", bus.out_valid_o, 0);
    chk("abort_in_ready", bus.in_ready_o, 0);
    rst = 1'b0;
    void'(exp_q.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid_o) seen = 1'b1;
    end
    chk("abort_no_emit", seen, 0);
    send(0, 1'b0, C1, P1);
    recv(0);
    check_trace(1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
